// File: rtl/clock_burst_sequencer.sv
// clock_burst_sequencer: drives the control inputs of one clock_state
// instance so that it emits bursts of exactly N clock cycles. Burst
// commands arrive over valid/ready; completed cycles are counted from the
// clock_state cycle-done pulses. A burst ends either paused at the idle
// level (HOLD) or with the clock stopped and its state cleared (STOP).

package common_p;
   typedef struct packed {
      logic clk;
      logic clk_en;
      logic sync_rst;
   } clk_dom;
endpackage

module clock_burst_sequencer #(
   parameter int unsigned CYCLE_WIDTH = 16
) (
   input  common_p::clk_dom         sys_dom_i,
   input  logic                     cmd_valid_i,
   output logic                     cmd_ready_o,
   input  logic [CYCLE_WIDTH-1:0]   cmd_cycles_i,
   input  logic                     cmd_idle_high_i,
   input  logic                     cmd_hold_i,
   input  logic                     abort_i,
   input  logic                     cycle_done_evt_i,
   output logic                     clock_active_o,
   output logic                     clear_state_o,
   output logic                     set_clock_low_o,
   output logic                     set_clock_high_o,
   output logic                     pause_en_o,
   output logic                     pause_polarity_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic [CYCLE_WIDTH-1:0]   remaining_o
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PARK = 3'd1,
      ST_RUN  = 3'd2,
      ST_HOLD = 3'd3,
      ST_STOP = 3'd4
   } state_t;

   localparam logic [CYCLE_WIDTH-1:0] CNT_ZERO = {CYCLE_WIDTH{1'b0}};
   localparam logic [CYCLE_WIDTH-1:0] CNT_ONE  = {{(CYCLE_WIDTH-1){1'b0}}, 1'b1};

   logic clk;
   logic clk_en_s;
   logic sync_rst_s;

   assign clk        = sys_dom_i.clk;
   assign clk_en_s   = sys_dom_i.clk_en;
   assign sync_rst_s = sys_dom_i.sync_rst;

   state_t                  state_r, state_nxt_s;
   logic [CYCLE_WIDTH-1:0]  remaining_r, remaining_nxt_s;
   logic                    idle_high_r, idle_high_nxt_s;
   logic                    hold_r, hold_nxt_s;
   logic                    stop_done_r, stop_done_nxt_s;
   logic                    done_r, done_nxt_s;
   logic                    clock_active_r, clock_active_nxt_s;
   logic                    clear_state_r, clear_state_nxt_s;
   logic                    set_low_r, set_low_nxt_s;
   logic                    set_high_r, set_high_nxt_s;
   logic                    pause_en_r, pause_en_nxt_s;
   logic                    busy_r, busy_nxt_s;
   logic                    cmd_ready_s;
   logic                    accept_s;
   logic                    cmd_zero_s;

   // An abort while holding withdraws readiness so the command is not taken.
   assign cmd_ready_s = (state_r == ST_IDLE) | ((state_r == ST_HOLD) & ~abort_i);
   assign accept_s    = cmd_valid_i & cmd_ready_s;
   assign cmd_zero_s  = (cmd_cycles_i == CNT_ZERO);

   // Next-state, counter and latch logic, plus output decode of the next state.
   always_comb begin
      state_nxt_s     = state_r;
      remaining_nxt_s = remaining_r;
      idle_high_nxt_s = idle_high_r;
      hold_nxt_s      = hold_r;
      stop_done_nxt_s = stop_done_r;
      done_nxt_s      = 1'b0;

      case (state_r)
         ST_IDLE: begin
            stop_done_nxt_s = 1'b0;
            if (accept_s) begin
               idle_high_nxt_s = cmd_idle_high_i;
               hold_nxt_s      = cmd_hold_i;
               remaining_nxt_s = cmd_cycles_i;
               if (cmd_zero_s) begin
                  done_nxt_s = 1'b1;
               end else begin
                  state_nxt_s = ST_PARK;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_PARK: begin
            if (abort_i) begin
               state_nxt_s     = ST_STOP;
               remaining_nxt_s = CNT_ZERO;
               stop_done_nxt_s = 1'b0;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort_i) begin
               state_nxt_s     = ST_STOP;
               remaining_nxt_s = CNT_ZERO;
               stop_done_nxt_s = 1'b0;
            end else if (cycle_done_evt_i) begin
               if (remaining_r <= CNT_ONE) begin
                  // Last cycle of the burst: never decrement below zero.
                  remaining_nxt_s = CNT_ZERO;
                  if (hold_r) begin
                     state_nxt_s = ST_HOLD;
                     done_nxt_s  = 1'b1;
                  end else begin
                     state_nxt_s     = ST_STOP;
                     stop_done_nxt_s = 1'b1;
                  end
               end else begin
                  remaining_nxt_s = remaining_r - CNT_ONE;
               end
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_HOLD: begin
            if (abort_i) begin
               state_nxt_s     = ST_STOP;
               remaining_nxt_s = CNT_ZERO;
               stop_done_nxt_s = 1'b0;
            end else if (accept_s) begin
               // Idle level is kept from the burst that parked the clock.
               remaining_nxt_s = cmd_cycles_i;
               hold_nxt_s      = cmd_hold_i;
               if (!cmd_zero_s) begin
                  state_nxt_s = ST_RUN;
               end else if (cmd_hold_i) begin
                  done_nxt_s = 1'b1;
               end else begin
                  state_nxt_s     = ST_STOP;
                  stop_done_nxt_s = 1'b1;
               end
            end else begin
               state_nxt_s = ST_HOLD;
            end
         end
         ST_STOP: begin
            state_nxt_s     = ST_IDLE;
            done_nxt_s      = stop_done_r;
            stop_done_nxt_s = 1'b0;
         end
         default: begin
            state_nxt_s     = ST_IDLE;
            remaining_nxt_s = CNT_ZERO;
            stop_done_nxt_s = 1'b0;
         end
      endcase

      clock_active_nxt_s = (state_nxt_s == ST_RUN) | (state_nxt_s == ST_HOLD);
      clear_state_nxt_s  = (state_nxt_s == ST_STOP);
      set_high_nxt_s     = (state_nxt_s == ST_PARK) & idle_high_nxt_s;
      set_low_nxt_s      = (state_nxt_s == ST_PARK) & ~idle_high_nxt_s;
      pause_en_nxt_s     = (state_nxt_s == ST_HOLD);
      busy_nxt_s         = (state_nxt_s != ST_IDLE);
   end

   // State, counter, latches and registered outputs; advance only on clk_en.
   always_ff @(posedge clk) begin
      if (sync_rst_s) begin
         state_r        <= ST_IDLE;
         remaining_r    <= CNT_ZERO;
         idle_high_r    <= 1'b0;
         hold_r         <= 1'b0;
         stop_done_r    <= 1'b0;
         done_r         <= 1'b0;
         clock_active_r <= 1'b0;
         clear_state_r  <= 1'b0;
         set_low_r      <= 1'b0;
         set_high_r     <= 1'b0;
         pause_en_r     <= 1'b0;
         busy_r         <= 1'b0;
      end else if (clk_en_s) begin
         state_r        <= state_nxt_s;
         remaining_r    <= remaining_nxt_s;
         idle_high_r    <= idle_high_nxt_s;
         hold_r         <= hold_nxt_s;
         stop_done_r    <= stop_done_nxt_s;
         done_r         <= done_nxt_s;
         clock_active_r <= clock_active_nxt_s;
         clear_state_r  <= clear_state_nxt_s;
         set_low_r      <= set_low_nxt_s;
         set_high_r     <= set_high_nxt_s;
         pause_en_r     <= pause_en_nxt_s;
         busy_r         <= busy_nxt_s;
      end
   end

   assign cmd_ready_o      = cmd_ready_s;
   assign clock_active_o   = clock_active_r;
   assign clear_state_o    = clear_state_r;
   assign set_clock_low_o  = set_low_r;
   assign set_clock_high_o = set_high_r;
   assign pause_en_o       = pause_en_r;
   assign pause_polarity_o = idle_high_r;
   assign busy_o           = busy_r;
   assign done_o           = done_r;
   assign remaining_o      = remaining_r;

endmodule

// File: tb/tb_clock_burst_sequencer.sv
// Self-checking bench for clock_burst_sequencer: directed bursts against a
// behavioural model of the burst rules, plus literal expectations.
module tb_clock_burst_sequencer;

   localparam int CW = 16;

   logic clk = 1'b0;
   logic clk_en = 1'b1;
   logic sync_rst = 1'b1;
   common_p::clk_dom dom;
   assign dom = {clk, clk_en, sync_rst};

   logic          cmd_valid = 1'b0;
   logic [CW-1:0] cmd_cycles = '0;
   logic          cmd_idle_high = 1'b0;
   logic          cmd_hold = 1'b0;
   logic          abort = 1'b0;
   logic          evt = 1'b0;

   logic          dut_ready, dut_active, dut_clear, dut_low, dut_high;
   logic          dut_pause, dut_pol, dut_busy, dut_done;
   logic [CW-1:0] dut_rem;

   clock_burst_sequencer #(.CYCLE_WIDTH(CW)) dut (
      .sys_dom_i(dom),
      .cmd_valid_i(cmd_valid),
      .cmd_ready_o(dut_ready),
      .cmd_cycles_i(cmd_cycles),
      .cmd_idle_high_i(cmd_idle_high),
      .cmd_hold_i(cmd_hold),
      .abort_i(abort),
      .cycle_done_evt_i(evt),
      .clock_active_o(dut_active),
      .clear_state_o(dut_clear),
      .set_clock_low_o(dut_low),
      .set_clock_high_o(dut_high),
      .pause_en_o(dut_pause),
      .pause_polarity_o(dut_pol),
      .busy_o(dut_busy),
      .done_o(dut_done),
      .remaining_o(dut_rem)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model: what the clock is doing, expressed as activity.
   localparam int M_IDLE = 0, M_PARKING = 1, M_CLOCKING = 2, M_PAUSED = 3, M_STOPPING = 4;
   int m_mode;
   int m_left;
   bit m_level, m_keep, m_done, m_report_at_stop;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic bit m_ready(input bit ab);
      return (m_mode == M_IDLE) || (m_mode == M_PAUSED && !ab);
   endfunction

   task automatic m_reset();
      m_mode = M_IDLE; m_left = 0; m_level = 0; m_keep = 0;
      m_done = 0; m_report_at_stop = 0;
   endtask

   task automatic m_abort();
      m_mode = M_STOPPING; m_left = 0; m_report_at_stop = 0;
   endtask

   task automatic m_step(input bit v, input int cyc, input bit ih, input bit hd,
                         input bit ab, input bit ev);
      bit take;
      take = v && m_ready(ab);
      m_done = 0;
      if (m_mode == M_IDLE) begin
         if (take) begin
            m_level = ih; m_keep = hd; m_left = cyc;
            if (cyc == 0) m_done = 1;
            else m_mode = M_PARKING;
         end
      end else if (m_mode == M_STOPPING) begin
         m_mode = M_IDLE;
         m_done = m_report_at_stop;
         m_report_at_stop = 0;
      end else if (ab) begin
         m_abort();
      end else if (m_mode == M_PARKING) begin
         m_mode = M_CLOCKING;
      end else if (m_mode == M_CLOCKING) begin
         if (ev) begin
            if (m_left > 0) m_left--;
            if (m_left == 0) begin
               if (m_keep) begin m_mode = M_PAUSED; m_done = 1; end
               else begin m_mode = M_STOPPING; m_report_at_stop = 1; end
            end
         end
      end else if (take) begin
         m_left = cyc; m_keep = hd;
         if (cyc != 0) m_mode = M_CLOCKING;
         else if (hd) m_done = 1;
         else begin m_mode = M_STOPPING; m_report_at_stop = 1; end
      end
   endtask

   // Compare every registered output against the model.
   task automatic check_all();
      chk("clock_active", dut_active, (m_mode == M_CLOCKING || m_mode == M_PAUSED));
      chk("clear_state", dut_clear, (m_mode == M_STOPPING));
      chk("set_clock_low", dut_low, (m_mode == M_PARKING && !m_level));
      chk("set_clock_high", dut_high, (m_mode == M_PARKING && m_level));
      chk("pause_en", dut_pause, (m_mode == M_PAUSED));
      chk("pause_polarity", dut_pol, m_level);
      chk("busy", dut_busy, (m_mode != M_IDLE));
      chk("done", dut_done, m_done);
      chk("remaining", dut_rem, m_left);
   endtask

   // One clock cycle: drive inputs after the falling edge, check, advance.
   task automatic step(input bit v, input int cyc, input bit ih, input bit hd,
                       input bit ab, input bit ev, input bit en);
      cmd_valid = v; cmd_cycles = cyc[CW-1:0]; cmd_idle_high = ih; cmd_hold = hd;
      abort = ab; evt = ev; clk_en = en;
      #1;
      chk("cmd_ready", dut_ready, m_ready(ab));
      @(posedge clk);
      if (sync_rst) m_reset();
      else if (en) m_step(v, cyc, ih, hd, ab, ev);
      @(negedge clk);
      check_all();
   endtask

   task automatic idle_cyc(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic ev_cyc();
      step(0, 0, 0, 0, 0, 1, 1);
   endtask

   int dec_cnt;
   int iters;
   logic [CW-1:0] prev_rem;

   initial begin
      // Reset for two cycles.
      sync_rst = 1'b1;
      repeat (2) @(posedge clk);
      m_reset();
      @(negedge clk);
      sync_rst = 1'b0;
      check_all();
      chk("rst_remaining", dut_rem, 0);
      chk("rst_cmd_ready", dut_ready, 1);
      chk("rst_busy", dut_busy, 0);
      chk("rst_active", dut_active, 0);

      // Burst of 3, idle low, stop at end.
      step(1, 3, 0, 0, 0, 0, 1);
      chk("b3_park_low", dut_low, 1);
      chk("b3_park_rem", dut_rem, 3);
      idle_cyc(1);
      chk("b3_run_active", dut_active, 1);
      ev_cyc();
      chk("b3_rem2", dut_rem, 2);
      ev_cyc();
      chk("b3_rem1", dut_rem, 1);
      ev_cyc();
      chk("b3_stop_clear", dut_clear, 1);
      chk("b3_stop_done", dut_done, 0);
      idle_cyc(1);
      chk("b3_done", dut_done, 1);
      chk("b3_idle_busy", dut_busy, 0);
      idle_cyc(1);
      chk("b3_done_gone", dut_done, 0);

      // Burst of 2, idle high, hold; then 4 more cycles straight from HOLD.
      step(1, 2, 1, 1, 0, 0, 1);
      chk("b2_park_high", dut_high, 1);
      idle_cyc(1);
      ev_cyc();
      ev_cyc();
      chk("b2_hold_pause", dut_pause, 1);
      chk("b2_hold_pol", dut_pol, 1);
      chk("b2_hold_done", dut_done, 1);
      idle_cyc(2);
      step(1, 4, 0, 1, 0, 0, 1);
      chk("b4_run_pause", dut_pause, 0);
      chk("b4_run_pol", dut_pol, 1);
      chk("b4_rem", dut_rem, 4);
      for (int i = 0; i < 4; i++) ev_cyc();
      chk("b4_hold_done", dut_done, 1);
      chk("b4_hold_pause", dut_pause, 1);
      // Zero-cycle hold command while paused, then abort out of HOLD.
      step(1, 0, 0, 1, 0, 0, 1);
      chk("h0_done", dut_done, 1);
      step(1, 6, 0, 1, 1, 0, 1);
      chk("habort_clear", dut_clear, 1);
      chk("habort_done", dut_done, 0);
      idle_cyc(1);
      chk("habort_idle_done", dut_done, 0);

      // Zero-cycle burst from IDLE: no parking, done one cycle later.
      step(1, 0, 1, 0, 0, 0, 1);
      chk("z_done", dut_done, 1);
      chk("z_busy", dut_busy, 0);
      chk("z_pol", dut_pol, 1);
      idle_cyc(2);

      // Abort in RUN at remaining 5 with coincident event and command.
      step(1, 7, 0, 1, 0, 0, 1);
      idle_cyc(1);
      ev_cyc();
      ev_cyc();
      chk("ab_rem5", dut_rem, 5);
      step(1, 9, 1, 0, 1, 1, 1);
      chk("ab_clear", dut_clear, 1);
      chk("ab_rem0", dut_rem, 0);
      chk("ab_done", dut_done, 0);
      idle_cyc(1);
      chk("ab_idle_done", dut_done, 0);
      chk("ab_pol_kept", dut_pol, 0);

      // Eight-cycle burst with clk_en randomly gated.
      step(1, 8, 0, 0, 0, 0, 1);
      dec_cnt = 0;
      iters = 0;
      while (m_mode != M_IDLE && iters < 400) begin
         prev_rem = dut_rem;
         step(0, 0, 0, 0, 0, $urandom_range(0, 1), $urandom_range(0, 1));
         if (dut_rem < prev_rem) dec_cnt++;
         iters++;
      end
      chk("en_finished", dut_busy, 0);
      chk("en_events", dec_cnt, 8);
      idle_cyc(2);

      // Synchronous reset mid-RUN overrides a low clk_en.
      step(1, 8, 1, 1, 0, 0, 1);
      idle_cyc(1);
      ev_cyc();
      sync_rst = 1'b1;
      step(0, 0, 0, 0, 0, 1, 0);
      sync_rst = 1'b0;
      chk("rst_mid_busy", dut_busy, 0);
      chk("rst_mid_pol", dut_pol, 0);
      chk("rst_mid_rem", dut_rem, 0);
      idle_cyc(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
